dcache_port_monitor: RTL and testbench

DCACHE_PORT_MONITOR -- requirements
Module: dcache_port_monitor

---
 rtl/dcache_mon_pkg.sv | 36 +++
 rtl/dcache_port_monitor_if.sv | 16 +
 rtl/dcache_port_tracker.sv | 115 +++++++++++
 rtl/dcache_port_monitor.sv | 122 ++++++++++++
 tb/tb_dcache_port_monitor.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_mon_pkg.sv
// Shared types and defaults for the dcache port monitor: request/response views,
// sticky error flags and the flush handshake FSM states.
package dcache_mon_pkg;

   localparam int unsigned DCACHE_INDEX_WIDTH = 12;

   localparam int unsigned DefaultNrPorts = 3;
   localparam int unsigned DefaultDepth   = 4;
   localparam int unsigned DefaultTimeout = 1024;

   // Only the fields the monitor observes are carried.
   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic                          data_req;
      logic                          data_we;
   } dcache_req_i_t;

   typedef struct packed {
      logic data_gnt;
      logic data_rvalid;
   } dcache_req_o_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic timeout;
      logic flush;
   } err_t;

   typedef enum logic [1:0] {
      FlushIdle,
      FlushActive,
      FlushAcked
   } flush_state_e;

endpackage

// File: rtl/dcache_port_monitor_if.sv
// Passive bundle of dcache request/response ports and the flush handshake.
interface dcache_port_monitor_if
   import dcache_mon_pkg::*;
#(
   parameter int unsigned NR_PORTS = DefaultNrPorts
);

   dcache_req_i_t [NR_PORTS-1:0] req;
   dcache_req_o_t [NR_PORTS-1:0] resp;
   logic                         flush;
   logic                         flush_ack;

   modport master (output req, resp, flush, flush_ack);
   modport slave  (input  req, resp, flush, flush_ack);

endinterface

// File: rtl/dcache_port_tracker.sv
// Per-port tracker: outstanding-load FIFO of address indices, age counter of the
// oldest load and a saturating granted-load counter.
module dcache_port_tracker
   import dcache_mon_pkg::*;
#(
   parameter int unsigned DEPTH   = DefaultDepth,
   parameter int unsigned TIMEOUT = DefaultTimeout
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              clear_i,
   input  dcache_req_i_t                     req_i,
   input  dcache_req_o_t                     resp_i,
   output logic                              rsp_valid_o,
   output logic [DCACHE_INDEX_WIDTH-1:0]     rsp_index_o,
   output logic [$clog2(DEPTH+1)-1:0]        outstanding_o,
   output logic [31:0]                       load_cnt_o,
   output logic                              overflow_o,
   output logic                              underflow_o,
   output logic                              timeout_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned AgeW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] Full   = CntW'(DEPTH);
   localparam logic [AgeW-1:0] AgeMax = AgeW'(TIMEOUT);

   logic [DEPTH-1:0][DCACHE_INDEX_WIDTH-1:0] mem_q, mem_d;
   logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]               cnt_q, cnt_d;
   logic [AgeW-1:0]               age_q, age_d;
   logic [31:0]                   load_cnt_q, load_cnt_d;
   logic                          rsp_valid_q, rsp_valid_d;
   logic [DCACHE_INDEX_WIDTH-1:0] rsp_index_q, rsp_index_d;

   logic grant, empty, full, push, pop;

   assign grant = req_i.data_req & resp_i.data_gnt & ~req_i.data_we;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == Full);
   assign pop   = resp_i.data_rvalid & ~empty;
   // A grant on a full FIFO is dropped but still counted as a load.
   assign push  = grant & ~full;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      age_d       = age_q;
      load_cnt_d  = load_cnt_q;
      rsp_valid_d = 1'b0;
      rsp_index_d = rsp_index_q;
      if (clear_i) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cnt_d       = '0;
         age_d       = '0;
         load_cnt_d  = '0;
         rsp_index_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = req_i.address_index;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rsp_valid_d = 1'b1;
            rsp_index_d = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + PtrW'(1);
         end
         cnt_d = cnt_q + CntW'(push) - CntW'(pop);
         if (pop || empty) begin
            age_d = '0;
         end else if (age_q != AgeMax) begin
            age_d = age_q + AgeW'(1);
         end
         if (grant && (load_cnt_q != '1)) begin
            load_cnt_d = load_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         age_q       <= '0;
         load_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_index_q <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         age_q       <= age_d;
         load_cnt_q  <= load_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_index_q <= rsp_index_d;
      end
   end

   assign overflow_o    = ~clear_i & grant & full;
   assign underflow_o   = ~clear_i & resp_i.data_rvalid & empty;
   // Fires only on the cycle the age first reaches the limit.
   assign timeout_o     = (age_d == AgeMax) & (age_q != AgeMax);
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_index_o   = rsp_index_q;
   assign outstanding_o = cnt_q;
   assign load_cnt_o    = load_cnt_q;

endmodule

// File: rtl/dcache_port_monitor.sv
// Passive dcache port monitor: per-port load trackers plus the flush handshake
// checker and sticky error aggregation.
module dcache_port_monitor
   import dcache_mon_pkg::*;
#(
   parameter int unsigned NR_PORTS = DefaultNrPorts,
   parameter int unsigned DEPTH    = DefaultDepth,
   parameter int unsigned TIMEOUT  = DefaultTimeout,
   localparam int unsigned PortW   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         clear_i,
   dcache_port_monitor_if.slave                         dcache_if,
   output logic [NR_PORTS-1:0]                          rsp_valid_o,
   output logic [NR_PORTS-1:0][DCACHE_INDEX_WIDTH-1:0]  rsp_index_o,
   output logic [NR_PORTS-1:0][$clog2(DEPTH+1)-1:0]     outstanding_o,
   output logic [NR_PORTS-1:0][31:0]                    load_cnt_o,
   output err_t                                         err_o,
   output logic [PortW-1:0]                             err_port_o
);

   logic [NR_PORTS-1:0] overflow, underflow, timeout, port_evt;

   for (genvar g = 0; g < NR_PORTS; g++) begin : gen_port
      dcache_port_tracker #(
         .DEPTH   (DEPTH),
         .TIMEOUT (TIMEOUT)
      ) u_tracker (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .clear_i       (clear_i),
         .req_i         (dcache_if.req[g]),
         .resp_i        (dcache_if.resp[g]),
         .rsp_valid_o   (rsp_valid_o[g]),
         .rsp_index_o   (rsp_index_o[g]),
         .outstanding_o (outstanding_o[g]),
         .load_cnt_o    (load_cnt_o[g]),
         .overflow_o    (overflow[g]),
         .underflow_o   (underflow[g]),
         .timeout_o     (timeout[g])
      );
   end

   assign port_evt = overflow | underflow | timeout;

   flush_state_e flush_state_q, flush_state_d;
   logic         flush_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         flush_state_q <= FlushIdle;
      end else begin
         flush_state_q <= flush_state_d;
      end
   end

   always_comb begin
      flush_state_d = flush_state_q;
      unique case (flush_state_q)
         FlushIdle: begin
            if (dcache_if.flush) flush_state_d = FlushActive;
         end
         FlushActive: begin
            if (dcache_if.flush_ack)   flush_state_d = FlushAcked;
            else if (!dcache_if.flush) flush_state_d = FlushIdle;
         end
         FlushAcked: flush_state_d = FlushIdle;
         default:    flush_state_d = FlushIdle;
      endcase
   end

   always_comb begin
      flush_err = 1'b0;
      unique case (flush_state_q)
         FlushIdle:   flush_err = dcache_if.flush_ack;
         FlushActive: flush_err = ~dcache_if.flush_ack & ~dcache_if.flush;
         FlushAcked:  flush_err = dcache_if.flush_ack;
         default:     flush_err = 1'b0;
      endcase
   end

   err_t             err_q, err_d;
   logic [PortW-1:0] err_port_q, err_port_d;
   logic             port_err_seen;

   assign port_err_seen = err_q.overflow | err_q.underflow | err_q.timeout;

   always_comb begin
      err_d      = err_q;
      err_port_d = err_port_q;
      if (clear_i) begin
         err_d      = '0;
         err_port_d = '0;
      end else begin
         err_d.overflow  = err_q.overflow  | (|overflow);
         err_d.underflow = err_q.underflow | (|underflow);
         err_d.timeout   = err_q.timeout   | (|timeout);
         err_d.flush     = err_q.flush     | flush_err;
         // Descending scan so the lowest-numbered erroring port wins.
         if (!port_err_seen && (|port_evt)) begin
            for (int i = NR_PORTS - 1; i >= 0; i--) begin
               if (port_evt[i]) err_port_d = PortW'(i);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q      <= '0;
         err_port_q <= '0;
      end else begin
         err_q      <= err_d;
         err_port_q <= err_port_d;
      end
   end

   assign err_o      = err_q;
   assign err_port_o = err_port_q;

endmodule

// File: tb/tb_dcache_port_monitor.sv
// Directed bench for dcache_port_monitor with hand-computed expectations.
module tb_dcache_port_monitor;
   import dcache_mon_pkg::*;

   localparam int unsigned NrPorts = 3;
   localparam int unsigned Depth   = 4;
   localparam int unsigned Timeout = 16;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic clear = 1'b0;

   logic [NrPorts-1:0]                          rsp_valid;
   logic [NrPorts-1:0][DCACHE_INDEX_WIDTH-1:0]  rsp_index;
   logic [NrPorts-1:0][$clog2(Depth+1)-1:0]     outst;
   logic [NrPorts-1:0][31:0]                    load_cnt;
   err_t                                        err;
   logic [1:0]                                  err_port;

   int unsigned checks = 0;
   int unsigned errors = 0;

   dcache_port_monitor_if #(.NR_PORTS(NrPorts)) dif ();

   dcache_port_monitor #(
      .NR_PORTS (NrPorts),
      .DEPTH    (Depth),
      .TIMEOUT  (Timeout)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear),
      .dcache_if     (dif.slave),
      .rsp_valid_o   (rsp_valid),
      .rsp_index_o   (rsp_index),
      .outstanding_o (outst),
      .load_cnt_o    (load_cnt),
      .err_o         (err),
      .err_port_o    (err_port)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      for (int p = 0; p < NrPorts; p++) begin
         dif.req[p]  = '0;
         dif.resp[p] = '0;
      end
      dif.flush     = 1'b0;
      dif.flush_ack = 1'b0;
   endtask

   task automatic load(input int p, input logic [11:0] idx);
      dif.req[p].data_req      = 1'b1;
      dif.req[p].data_we       = 1'b0;
      dif.req[p].address_index = idx;
      dif.resp[p].data_gnt     = 1'b1;
   endtask

   task automatic rvalid(input int p);
      dif.resp[p].data_rvalid = 1'b1;
   endtask

   task automatic pulse_clear();
      idle();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      idle();
      tick();
      tick();
      check_eq("rst_valid", rsp_valid, 0);
      check_eq("rst_outst", outst, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_cnt", load_cnt, 0);
      check_eq("rst_port", err_port, 0);
      rst_ni = 1'b1;
      tick();

      // Store on port 2 is ignored.
      dif.req[2].data_req  = 1'b1;
      dif.req[2].data_we   = 1'b1;
      dif.resp[2].data_gnt = 1'b1;
      tick();
      idle();
      check_eq("store_outst", outst[2], 0);
      check_eq("store_cnt", load_cnt[2], 0);

      // Two loads on port 1, each answered three cycles later.
      check_eq("nom_occ0", outst[1], 0);
      load(1, 12'h010);
      tick();
      check_eq("nom_occ1", outst[1], 1);
      idle();
      load(1, 12'h020);
      tick();
      check_eq("nom_occ2", outst[1], 2);
      idle();
      tick();
      check_eq("nom_occ2b", outst[1], 2);
      rvalid(1);
      tick();
      check_eq("nom_v1", rsp_valid[1], 1);
      check_eq("nom_idx1", rsp_index[1], 12'h010);
      check_eq("nom_occ3", outst[1], 1);
      tick();
      check_eq("nom_v2", rsp_valid[1], 1);
      check_eq("nom_idx2", rsp_index[1], 12'h020);
      check_eq("nom_occ4", outst[1], 0);
      idle();
      tick();
      check_eq("nom_vlow", rsp_valid[1], 0);
      check_eq("nom_hold", rsp_index[1], 12'h020);
      check_eq("nom_err", err, 0);
      check_eq("nom_cnt", load_cnt[1], 2);
      pulse_clear();

      // Pointer wrap with simultaneous push/pop.
      load(0, 12'h100);
      tick();
      for (int k = 1; k <= 6; k++) begin
         idle();
         load(0, 12'(12'h100 + k));
         rvalid(0);
         tick();
         check_eq("wrap_idx", rsp_index[0], 64'(12'h100 + k - 1));
         check_eq("wrap_occ", outst[0], 1);
      end
      idle();
      rvalid(0);
      tick();
      check_eq("wrap_last", rsp_index[0], 12'h106);
      check_eq("wrap_empty", outst[0], 0);
      pulse_clear();

      // Overflow on port 0.
      for (int k = 0; k < 5; k++) begin
         idle();
         load(0, 12'(k + 1));
         tick();
      end
      idle();
      check_eq("ovf_occ", outst[0], 4);
      check_eq("ovf_flag", err.overflow, 1);
      check_eq("ovf_port", err_port, 0);
      check_eq("ovf_cnt", load_cnt[0], 5);
      load(0, 12'h006);
      rvalid(0);
      tick();
      check_eq("ovf_pop_occ", outst[0], 3);
      check_eq("ovf_pop_idx", rsp_index[0], 12'h001);
      check_eq("ovf_pop_cnt", load_cnt[0], 6);

      // Clear while errors set and loads in flight.
      pulse_clear();
      check_eq("clr_err", err, 0);
      check_eq("clr_occ", outst, 0);
      check_eq("clr_cnt", load_cnt, 0);
      check_eq("clr_valid", rsp_valid, 0);

      // Underflow on port 2.
      rvalid(2);
      tick();
      idle();
      check_eq("unf_valid", rsp_valid[2], 0);
      check_eq("unf_flag", err.underflow, 1);
      check_eq("unf_port", err_port, 2);
      tick();
      check_eq("unf_sticky", err.underflow, 1);
      pulse_clear();

      // Grant plus rvalid on empty port 1, rvalid on empty port 2.
      load(1, 12'h055);
      rvalid(1);
      rvalid(2);
      tick();
      idle();
      check_eq("unf2_port", err_port, 1);
      check_eq("unf2_occ", outst[1], 1);
      check_eq("unf2_valid", rsp_valid[1], 0);
      rvalid(1);
      tick();
      idle();
      check_eq("unf2_idx", rsp_index[1], 12'h055);
      pulse_clear();

      // Timeout exactly Timeout cycles after the grant.
      load(0, 12'h007);
      tick();
      idle();
      repeat (Timeout - 1) tick();
      check_eq("tmo_early", err.timeout, 0);
      tick();
      check_eq("tmo_flag", err.timeout, 1);
      check_eq("tmo_port", err_port, 0);
      pulse_clear();

      // Legal flush: 5 cycles high, ack on the last.
      dif.flush = 1'b1;
      repeat (4) tick();
      dif.flush_ack = 1'b1;
      tick();
      idle();
      tick();
      tick();
      check_eq("flush_ok", err.flush, 0);

      // Two-cycle ack.
      dif.flush = 1'b1;
      tick();
      tick();
      dif.flush_ack = 1'b1;
      tick();
      dif.flush = 1'b0;
      tick();
      idle();
      tick();
      check_eq("flush_2ack", err.flush, 1);
      pulse_clear();
      check_eq("flush_clr", err.flush, 0);

      // Ack while idle.
      dif.flush_ack = 1'b1;
      tick();
      idle();
      tick();
      check_eq("flush_idle_ack", err.flush, 1);
      pulse_clear();

      // Flush dropped without ack.
      dif.flush = 1'b1;
      tick();
      tick();
      idle();
      tick();
      check_eq("flush_drop", err.flush, 1);
      pulse_clear();

      // Asynchronous reset mid-transaction.
      load(1, 12'h033);
      tick();
      idle();
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("arst_occ", outst[1], 0);
      check_eq("arst_cnt", load_cnt[1], 0);
      tick();
      rst_ni = 1'b1;
      load(1, 12'h044);
      tick();
      idle();
      rvalid(1);
      tick();
      idle();
      check_eq("arst_valid", rsp_valid[1], 1);
      check_eq("arst_idx", rsp_index[1], 12'h044);
      check_eq("arst_err", err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
